// File: rtl/apb_mem_slave_p_if.sv
// ============================================================================
// Module   : apb_mem_slave_p_if
// Purpose  : APB4 bus bundle between the master/decoder and apb_mem_slave_p.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_mem_slave_p_if #(
    parameter int DATA_W = 32,
    parameter int WAIT_W = 4
);
    logic                  _PSEL;
    logic                  _PENABLE;
    logic                  _PWRITE;
    logic [31:0]           _PADDR;
    logic [DATA_W-1:0]     _PWDATA;
    logic [DATA_W/8-1:0]   _PSTRB;
    logic [WAIT_W-1:0]     _WAIT;
    logic [DATA_W-1:0]     _PRDATA;
    logic                  _PREADY;
    logic                  _PSLVERR;

    modport master (
        output _PSEL, _PENABLE, _PWRITE, _PADDR, _PWDATA, _PSTRB, _WAIT,
        input  _PRDATA, _PREADY, _PSLVERR
    );

    modport slave (
        input  _PSEL, _PENABLE, _PWRITE, _PADDR, _PWDATA, _PSTRB, _WAIT,
        output _PRDATA, _PREADY, _PSLVERR
    );
endinterface

`default_nettype wire

// File: rtl/apb_mem_slave_p.sv
// ============================================================================
// Module   : apb_mem_slave_p
// Purpose  : APB4 word-addressed RAM slave with byte strobes, programmable
//            wait states, a read-only window and PSLVERR reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_mem_slave_p #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 5,
    parameter int WAIT_W  = 4,
    parameter int RO_BASE = 24,
    parameter int RO_SIZE = 8
) (
    input  wire                   _PCLK,
    input  wire                   _PRESETn,
    apb_mem_slave_p_if.slave      bus
);
    localparam int          c_nb    = DATA_W / 8;
    localparam int          c_words = 2 ** DEPTH;
    localparam logic [31:0] c_ro_lo = 32'(RO_BASE);
    localparam logic [31:0] c_ro_hi = 32'(RO_BASE + RO_SIZE);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_cnt;
    logic [31:0]         r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_nb-1:0]     r_strb;
    logic [DATA_W-1:0]   r_mem [c_words];

    logic                w_ready;
    logic                w_oor;
    logic                w_ro;
    logic                w_err;
    logic [DEPTH-1:0]    w_idx;

    // Out-of-range takes precedence, so the RO check only applies to in-range words.
    assign w_idx   = r_addr[DEPTH-1:0];
    assign w_oor   = (r_addr >> DEPTH) != 32'd0;
    assign w_ro    = (RO_SIZE != 0) && r_write && !w_oor &&
                     (r_addr >= c_ro_lo) && (r_addr < c_ro_hi);
    assign w_err   = w_oor || w_ro;
    assign w_ready = (r_state == ST_ACCESS) && bus._PSEL && (r_cnt == '0);

    assign bus._PREADY  = w_ready;
    assign bus._PSLVERR = w_ready && w_err;
    assign bus._PRDATA  = (w_ready && !r_write && !w_oor) ? r_mem[w_idx] : '0;

    always_ff @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            for (int i = 0; i < c_words; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus._PSEL && !bus._PENABLE) begin
                        r_state <= ST_ACCESS;
                        r_addr  <= bus._PADDR;
                        r_write <= bus._PWRITE;
                        r_wdata <= bus._PWDATA;
                        r_strb  <= bus._PSTRB;
                        r_cnt   <= bus._WAIT;
                    end
                end
                ST_ACCESS: begin
                    if (!bus._PSEL) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (r_write && !w_err) begin
                            for (int i = 0; i < c_nb; i++) begin
                                if (r_strb[i]) begin
                                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                                end
                            end
                        end
                        // A setup phase presented on the completion edge chains straight in.
                        if (!bus._PENABLE) begin
                            r_state <= ST_ACCESS;
                            r_addr  <= bus._PADDR;
                            r_write <= bus._PWRITE;
                            r_wdata <= bus._PWDATA;
                            r_strb  <= bus._PSTRB;
                            r_cnt   <= bus._WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave_p.sv
// ============================================================================
// Module   : tb_apb_mem_slave_p
// Purpose  : Self-checking bench for apb_mem_slave_p against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_mem_slave_p;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 5;
    localparam int WAIT_W  = 4;
    localparam int RO_BASE = 24;
    localparam int RO_SIZE = 8;

    logic _PCLK    = 1'b0;
    logic _PRESETn = 1'b0;
    always #5 _PCLK = ~_PCLK;

    apb_mem_slave_p_if #(.DATA_W(DATA_W), .WAIT_W(WAIT_W)) bus ();

    apb_mem_slave_p #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_W(WAIT_W),
        .RO_BASE(RO_BASE), .RO_SIZE(RO_SIZE)
    ) dut (
        ._PCLK(_PCLK),
        ._PRESETn(_PRESETn),
        .bus(bus)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic [31:0] model [32];

    always @(posedge _PCLK) cyc++;

    // Reference: an access errors if out of range, or a write into the RO window.
    task automatic model_xfer(input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              output logic [31:0] exp_rd, output logic exp_err);
        logic oor;
        oor     = addr >= 32'(2 ** DEPTH);
        exp_err = oor || (wr && addr >= RO_BASE && addr < RO_BASE + RO_SIZE);
        exp_rd  = (oor || wr) ? 32'd0 : model[addr[4:0]];
        if (wr && !exp_err)
            for (int i = 0; i < 4; i++)
                if (strb[i]) model[addr[4:0]][8*i +: 8] = data[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic idle();
        bus._PSEL = 1'b0; bus._PENABLE = 1'b0;
        @(posedge _PCLK); #1;
    endtask

    // One APB transfer; address/data/wait are scrambled during the access phase.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int w,
                        output logic [31:0] rdata, output logic err,
                        output int cycles, output int lows);
        int unsigned start;
        bit done;
        start = cyc; lows = 0; rdata = '0; err = 1'b0; done = 0;
        bus._PSEL = 1'b1; bus._PENABLE = 1'b0; bus._PWRITE = wr; bus._PADDR = addr;
        bus._PWDATA = data; bus._PSTRB = strb; bus._WAIT = w[WAIT_W-1:0];
        @(posedge _PCLK); #1;
        bus._PENABLE = 1'b1; bus._PADDR = $urandom; bus._PWDATA = $urandom;
        bus._WAIT = WAIT_W'($urandom);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge _PCLK);
            if (bus._PREADY === 1'b1) begin
                rdata = bus._PRDATA; err = bus._PSLVERR; done = 1;
            end else begin
                lows++;
                total++;
                if (bus._PRDATA !== '0 || bus._PSLVERR !== 1'b0) begin
                    bad++;
                    $display("FAIL wait_outputs: prdata=%h pslverr=%b required 0/0",
                             bus._PRDATA, bus._PSLVERR);
                end
            end
            @(posedge _PCLK); #1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL timeout: no PREADY within 40 cycles addr=%0d", addr);
        end
        cycles = int'(cyc - start);
    endtask

    task automatic test_reset();
        bus._PSEL = 0; bus._PENABLE = 0; bus._PWRITE = 0; bus._PADDR = 0;
        bus._PWDATA = 0; bus._PSTRB = 0; bus._WAIT = 0;
        model_clear();
        repeat (2) @(negedge _PCLK);
        total++;
        if (bus._PREADY !== 1'b0 || bus._PSLVERR !== 1'b0 || bus._PRDATA !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b err=%b rdata=%h required 0/0/0",
                     bus._PREADY, bus._PSLVERR, bus._PRDATA);
        end
        @(posedge _PCLK); #1;
        _PRESETn = 1'b1;
        idle();
        // PENABLE high while idle must not start a transfer.
        bus._PSEL = 1'b1; bus._PENABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge _PCLK);
            total++;
            if (bus._PREADY !== 1'b0) begin
                bad++;
                $display("FAIL idle_penable: pready=%b required 0", bus._PREADY);
            end
        end
        @(posedge _PCLK); #1;
        idle();
    endtask

    task automatic test_basic();
        logic [31:0] rd, er; logic err, ee; int cy, lo;
        model_xfer(1, 3, 32'hDEADBEEF, 4'hF, er, ee);
        xfer(1, 3, 32'hDEADBEEF, 4'hF, 0, rd, err, cy, lo);
        total++;
        if (cy !== 2 || err !== 1'b0) begin
            bad++; $display("FAIL basic_write: cycles=%0d err=%b required 2/0", cy, err);
        end
        idle();
        model_xfer(0, 3, 0, 0, er, ee);
        xfer(0, 3, 0, 4'h0, 0, rd, err, cy, lo);
        total++;
        if (cy !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_read: cycles=%0d err=%b data=%h required 2/0/deadbeef", cy, err, rd);
        end
        idle();
    endtask

    task automatic test_wait();
        logic [31:0] rd, er; logic err, ee; int cy, lo;
        model_xfer(0, 3, 0, 0, er, ee);
        xfer(0, 3, 0, 4'h0, 5, rd, err, cy, lo);
        total++;
        if (cy !== 7 || lo !== 5 || rd !== er || err !== ee) begin
            bad++;
            $display("FAIL wait5_read: cycles=%0d lows=%0d data=%h err=%b required 7/5/%h/%b",
                     cy, lo, rd, err, er, ee);
        end
        idle();
    endtask

    task automatic test_strobe();
        logic [31:0] rd, er; logic err, ee; int cy, lo;
        model_xfer(1, 7, 32'h11223344, 4'hF, er, ee);
        xfer(1, 7, 32'h11223344, 4'hF, 1, rd, err, cy, lo);
        model_xfer(1, 7, 32'hAABBCCDD, 4'h5, er, ee);
        xfer(1, 7, 32'hAABBCCDD, 4'h5, 0, rd, err, cy, lo);
        model_xfer(1, 7, 32'hFFFFFFFF, 4'h0, er, ee);
        xfer(1, 7, 32'hFFFFFFFF, 4'h0, 0, rd, err, cy, lo);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL strb_zero_err: err=%b required 0", err);
        end
        idle();
        model_xfer(0, 7, 0, 0, er, ee);
        xfer(0, 7, 0, 4'h0, 2, rd, err, cy, lo);
        total++;
        if (rd !== 32'h11BB33DD || er !== 32'h11BB33DD) begin
            bad++; $display("FAIL strobe_merge: data=%h model=%h required 11bb33dd", rd, er);
        end
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd, er; logic err, ee; int cy, lo;
        logic [31:0] addrs [4] = '{32'd32, 32'd25, 32'd25, 32'd40};
        logic        wrs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            model_xfer(wrs[i], addrs[i], 32'hCAFEF00D, 4'hF, er, ee);
            xfer(wrs[i], addrs[i], 32'hCAFEF00D, 4'hF, i, rd, err, cy, lo);
            total++;
            if (err !== ee || (!wrs[i] && rd !== er) || cy !== 2 + i) begin
                bad++;
                $display("FAIL err_case%0d: err=%b data=%h cycles=%0d required %b/%h/%0d",
                         i, err, rd, cy, ee, er, 2 + i);
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, er; logic err, ee; int cy, lo;
        int unsigned start;
        logic [31:0] vals [3];
        for (int i = 0; i < 3; i++) vals[i] = $urandom;
        start = cyc;
        for (int i = 0; i < 3; i++) begin
            model_xfer(1, i, vals[i], 4'hF, er, ee);
            xfer(1, i, vals[i], 4'hF, 0, rd, err, cy, lo);
        end
        total++;
        if (int'(cyc - start) !== 6) begin
            bad++; $display("FAIL b2b_cycles: cycles=%0d required 6", cyc - start);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            model_xfer(0, i, 0, 0, er, ee);
            xfer(0, i, 0, 4'h0, 0, rd, err, cy, lo);
            total++;
            if (rd !== vals[i] || err !== 1'b0) begin
                bad++; $display("FAIL b2b_read%0d: data=%h required %h", i, rd, vals[i]);
            end
        end
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd, er; logic err, ee; int cy, lo;
        bus._PSEL = 1; bus._PENABLE = 0; bus._PWRITE = 1; bus._PADDR = 9;
        bus._PWDATA = 32'h12345678; bus._PSTRB = 4'hF; bus._WAIT = 2;
        @(posedge _PCLK); #1;
        bus._PENABLE = 1;
        @(posedge _PCLK); #1;
        idle();
        model_xfer(0, 9, 0, 0, er, ee);
        xfer(0, 9, 0, 4'h0, 0, rd, err, cy, lo);
        total++;
        if (rd !== er || err !== 1'b0) begin
            bad++; $display("FAIL abort_nowrite: data=%h required %h", rd, er);
        end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, er, a, d; logic err, ee, wr; logic [3:0] s; int cy, lo, w;
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom); a = $urandom_range(0, 47); d = $urandom;
            s  = 4'($urandom); w = $urandom_range(0, 15);
            model_xfer(wr, a, d, s, er, ee);
            xfer(wr, a, d, s, w, rd, err, cy, lo);
            total++;
            if (cy !== 2 + w || lo !== w || err !== ee || (!wr && rd !== er)) begin
                bad++;
                $display("FAIL random%0d: wr=%b addr=%0d cycles=%0d err=%b data=%h required %0d/%b/%h",
                         n, wr, a, cy, err, rd, 2 + w, ee, er);
            end
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int cy, lo;
        bus._PSEL = 1; bus._PENABLE = 0; bus._PWRITE = 1; bus._PADDR = 4;
        bus._PWDATA = 32'hA5A5A5A5; bus._PSTRB = 4'hF; bus._WAIT = 3;
        @(posedge _PCLK); #1;
        bus._PENABLE = 1;
        @(posedge _PCLK); #1;
        _PRESETn = 1'b0;
        model_clear();
        #1;
        total++;
        if (bus._PREADY !== 1'b0 || bus._PSLVERR !== 1'b0 || bus._PRDATA !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: ready=%b err=%b rdata=%h required 0/0/0",
                     bus._PREADY, bus._PSLVERR, bus._PRDATA);
        end
        bus._PSEL = 0; bus._PENABLE = 0;
        @(posedge _PCLK); #1;
        _PRESETn = 1'b1;
        idle();
        xfer(0, 4, 0, 4'h0, 1, rd, err, cy, lo);
        total++;
        if (rd !== 32'd0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_mid_read: data=%h err=%b required 0/0", rd, err);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

`default_nettype wire
